// File: rtl/pwl_fma_float.sv
// pwl_fma_float: 4-stage single-precision y = m*data + c for the PWL activation path.
// Denormals flush to zero, every truncation rounds toward zero, any exponent of 255 yields NAN_VAL.
module pwl_fma_float #(
    parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data,
    input  logic [31:0] m,
    input  logic [31:0] c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);
    logic               en;
    logic [7:0]         ex, em, ec;
    logic [23:0]        mx, mm;
    logic               v1, s1_ps, s1_cs, s1_spec, s1_pz, s1_cz;
    logic signed [10:0] s1_pe;
    logic [27:0]        s1_p;
    logic [7:0]         s1_ce;
    logic [23:0]        s1_cm;
    logic [26:0]        pm, cm, a, b_raw, b;
    logic signed [10:0] pe_n, ce_s, diff;
    logic               p_big;
    logic               v2, s2_sa, s2_sb, s2_spec;
    logic [26:0]        s2_a, s2_b;
    logic signed [10:0] s2_e;
    logic               same, a_ge, sgn;
    logic [27:0]        sum;
    logic               v3, s3_s, s3_spec;
    logic [27:0]        s3_sum;
    logic signed [10:0] s3_e;
    logic [4:0]         pos;
    logic signed [10:0] re;
    logic [22:0]        frac;
    logic [31:0]        y_n;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_comb begin
        ex = data[30:23];
        em = m[30:23];
        ec = c[30:23];
        mx = (ex == 8'd0) ? 24'd0 : {1'b1, data[22:0]};
        mm = (em == 8'd0) ? 24'd0 : {1'b1, m[22:0]};
    end

    // Product is normalised to 1.xx with 26 fraction bits; the smaller-exponent operand is aligned.
    always_comb begin
        pm    = s1_p[27] ? s1_p[27:1] : s1_p[26:0];
        pe_n  = s1_pe + (s1_p[27] ? 11'sd1 : 11'sd0);
        cm    = {s1_cm, 3'b000};
        ce_s  = $signed({3'b000, s1_ce});
        p_big = ~s1_pz & (s1_cz | (pe_n >= ce_s));
        diff  = p_big ? pe_n - ce_s : ce_s - pe_n;
        a     = p_big ? pm : cm;
        b_raw = p_big ? cm : pm;
        b     = (diff < 11'sd0 || diff > 11'sd26) ? 27'd0 : b_raw >> diff[4:0];
    end

    always_comb begin
        same = s2_sa == s2_sb;
        a_ge = s2_a >= s2_b;
        sum  = same ? {1'b0, s2_a} + {1'b0, s2_b} : a_ge ? {1'b0, s2_a - s2_b} : {1'b0, s2_b - s2_a};
        sgn  = (same | a_ge) ? s2_sa : s2_sb;
    end

    always_comb begin
        pos = 5'd0;
        for (int i = 0; i < 28; i++)
            if (s3_sum[i]) pos = 5'(i);
        re   = s3_e + $signed({6'b000000, pos}) - 11'sd26;
        frac = 23'((s3_sum << (5'd27 - pos)) >> 4);
        y_n  = s3_spec ? NAN_VAL :
               (s3_sum == 28'd0) ? 32'h0 :
               (re >= 11'sd255) ? {s3_s, 8'hFF, 23'h0} :
               (re <= 11'sd0) ? {s3_s, 31'h0} :
               {s3_s, re[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, s1_ps, s1_cs, s1_spec, s1_pz, s1_cz} <= '0;
            s1_pe     <= '0;
            s1_p      <= '0;
            s1_ce     <= '0;
            s1_cm     <= '0;
            {v2, s2_sa, s2_sb, s2_spec} <= '0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_e      <= '0;
            {v3, s3_s, s3_spec} <= '0;
            s3_sum    <= '0;
            s3_e      <= '0;
            out_valid <= 1'b0;
            y         <= 32'h0;
        end else if (en) begin
            v1        <= in_valid;
            s1_ps     <= data[31] ^ m[31];
            s1_cs     <= c[31] & (ec != 8'd0);
            s1_spec   <= (ex == 8'hFF) | (em == 8'hFF) | (ec == 8'hFF);
            s1_pz     <= (ex == 8'd0) | (em == 8'd0);
            s1_cz     <= ec == 8'd0;
            s1_pe     <= $signed({3'b000, ex}) + $signed({3'b000, em}) - 11'sd127;
            s1_p      <= 28'((48'(mx) * 48'(mm)) >> 20);
            s1_ce     <= ec;
            s1_cm     <= (ec == 8'd0) ? 24'd0 : {1'b1, c[22:0]};
            v2        <= v1;
            s2_sa     <= p_big ? s1_ps : s1_cs;
            s2_sb     <= p_big ? s1_cs : s1_ps;
            s2_spec   <= s1_spec;
            s2_a      <= a;
            s2_b      <= b;
            s2_e      <= p_big ? pe_n : ce_s;
            v3        <= v2;
            s3_s      <= sgn;
            s3_spec   <= s2_spec;
            s3_sum    <= sum;
            s3_e      <= s2_e;
            out_valid <= v3;
            y         <= y_n;
        end
    end
endmodule

// File: tb/tb_pwl_fma_float.sv
// tb_pwl_fma_float: directed vectors, streaming/stall/reset sequences and a randomized scoreboard run.
module tb_pwl_fma_float;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] data = '0, m = '0, c = '0;
    logic        in_ready, out_valid;
    logic [31:0] y;

    pwl_fma_float dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .m(m), .c(c), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m, x, c, exp;
    } vec_t;

    int          n_vec = 0, n_err = 0;
    logic [31:0] q[$];
    logic [31:0] got[$];
    logic [31:0] vals[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    vec_t        tbl[12];
    int          lat, idx, first_k, last_k;
    logic [31:0] held;
    bit          pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint al(input longint v, input int k);
        return (k < 0) ? v : (k >= 27) ? 64'sd0 : (v >> k);
    endfunction

    // Value-level reference: signed integer add of the two aligned magnitudes, truncating everywhere.
    function automatic logic [31:0] ref_fma(input logic [31:0] mv, input logic [31:0] xv, input logic [31:0] cv);
        int     ex, em, ec, pe, e, pos, e2;
        longint pv, cmag, s, mag;
        logic   sn;
        logic [22:0] fr;
        ex = int'(xv[30:23]);
        em = int'(mv[30:23]);
        ec = int'(cv[30:23]);
        if (ex == 255 || em == 255 || ec == 255) return 32'h7FC00000;
        pv = (ex == 0 || em == 0) ? 64'sd0 : longint'({1'b1, xv[22:0]}) * longint'({1'b1, mv[22:0]});
        pe = ex + em - 127;
        if (pv >= (64'sd1 <<< 47)) begin
            pv = pv >> 21;
            pe = pe + 1;
        end else pv = pv >> 20;
        cmag = (ec == 0) ? 64'sd0 : (longint'({1'b1, cv[22:0]}) <<< 3);
        e = (pv == 0) ? ec : (cmag == 0) ? pe : (pe > ec ? pe : ec);
        pv   = al(pv, e - pe);
        cmag = al(cmag, e - ec);
        s = ((mv[31] ^ xv[31]) ? -pv : pv) + (cv[31] ? -cmag : cmag);
        if (s == 0) return 32'h0;
        sn  = s < 0;
        mag = sn ? -s : s;
        pos = 62;
        while (pos > 0 && !mag[pos]) pos--;
        e2 = e + pos - 26;
        if (e2 >= 255) return {sn, 8'hFF, 23'h0};
        if (e2 <= 0) return {sn, 31'h0};
        fr = (pos >= 23) ? 23'(mag >> (pos - 23)) : 23'(mag << (23 - pos));
        return {sn, 8'(e2), fr};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int r;
        logic [7:0] e;
        r = int'($urandom_range(0, 31));
        e = (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : (r < 4) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(115, 140));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Scoreboard: every accepted input must come out once, in order, with the reference value.
    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious output: got y=%h, expected no output", y);
                end else chk("scoreboard y", y, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(ref_fma(m, data, c));
        end
    end

    initial begin
        tbl[0]  = '{32'h40000000, 32'h3FC00000, 32'h3F000000, 32'h40600000};
        tbl[1]  = '{32'hBF000000, 32'h40800000, 32'h40000000, 32'h00000000};
        tbl[2]  = '{32'h3F800000, 32'h00400000, 32'h40400000, 32'h40400000};
        tbl[3]  = '{32'h7F000000, 32'h7F000000, 32'h00000000, 32'h7F800000};
        tbl[4]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
        tbl[5]  = '{32'h3F800000, 32'h3F800000, 32'hFF800000, 32'h7FC00000};
        tbl[6]  = '{32'h3F800000, 32'h3F800000, 32'hC0400000, 32'hC0000000};
        tbl[7]  = '{32'h80800000, 32'h00800000, 32'h00000000, 32'h80000000};
        tbl[8]  = '{32'h00000000, 32'h3F800000, 32'h80000001, 32'h00000000};
        tbl[9]  = '{32'h3F800001, 32'h3F800001, 32'h00000000, 32'h3F800002};
        tbl[10] = '{32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h4B800000};
        tbl[11] = '{32'hC0000000, 32'h40400000, 32'h3F800000, 32'hC0A00000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset y", y, 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            m = tbl[i].m; data = tbl[i].x; c = tbl[i].c; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("table[%0d] latency", i), 32'(lat), 32'd4);
            chk($sformatf("table[%0d] y", i), y, tbl[i].exp);
        end

        repeat (3) @(posedge clk);
        got.delete(); first_k = -1; last_k = -1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            in_valid = k < 8; m = 32'h3F800000; c = 32'h0;
            if (k < 8) data = vals[k];
            #1;
            if (out_valid) begin
                got.push_back(y);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        chk("stream count", 32'(got.size()), 32'd8);
        chk("stream first cycle", 32'(first_k), 32'd4);
        chk("stream last cycle", 32'(last_k), 32'd11);
        for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("stream y[%0d]", i), got[i], vals[i]);

        repeat (3) @(posedge clk);
        got.delete(); idx = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            out_ready = !(k >= 6 && k <= 8);
            in_valid = idx < 6;
            if (idx < 6) data = vals[idx];
            #1;
            if (k >= 6 && k <= 8) begin
                chk("stall in_ready", 32'(in_ready), 32'd0);
                chk("stall out_valid", 32'(out_valid), 32'd1);
                if (k > 6) chk("stall y held", y, held);
                held = y;
            end
            if (out_valid && out_ready) got.push_back(y);
            if (in_valid && in_ready) idx++;
        end
        chk("backpressure count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("backpressure y[%0d]", i), got[i], vals[i]);

        repeat (3) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; data = vals[k + 2];
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset y", y, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("flushed item emerged", 32'(out_valid), 32'd0);
        end

        pend = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (!pend) begin
                in_valid = $urandom_range(0, 3) != 0;
                m = rnd_fp(); data = rnd_fp(); c = rnd_fp();
                if ($urandom_range(0, 7) == 0) c = {~(m[31] ^ data[31]), 8'($urandom_range(120, 135)), 23'($urandom)};
            end
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            pend = in_valid && !in_ready;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain queue empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
